// File: rtl/mem_access_seq_if.sv
// rtl/mem_access_seq_if.sv - control-side request/response and memory-side bus bundle for mem_access_seq
interface mem_access_seq_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        align_err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req, op, addr, wdata, mem_rdata,
        output busy, done, align_err, rdata, mem_addr, mem_wr, mem_wdata
    );

    modport master (
        output req, op, addr, wdata, mem_rdata,
        input  busy, done, align_err, rdata, mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - multicycle load/store sequencer with read-modify-write for sub-word stores
module mem_access_seq #(
    parameter int READ_LAT = 2,
    parameter bit SIGN_EXT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    mem_access_seq_if.slave  bus
);
    localparam logic [2:0] OP_LW = 3'd0;
    localparam logic [2:0] OP_LH = 3'd1;
    localparam logic [2:0] OP_LB = 3'd2;
    localparam logic [2:0] OP_SW = 3'd3;
    localparam logic [2:0] OP_SH = 3'd4;
    localparam logic [2:0] OP_SB = 3'd5;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [2:0]  cnt;
    logic        busy_q;
    logic        done_q;
    logic        align_err_q;
    logic        mem_wr_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.align_err = align_err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_wdata = mem_wdata_q;

    function automatic logic bad_req(input logic [2:0] op, input logic [1:0] a);
        return (op > OP_SB)
            || ((op == OP_LW || op == OP_SW) && a != 2'b00)
            || ((op == OP_LH || op == OP_SH) && a[0]);
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] w);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = a[1] ? w[31:16] : w[15:0];
        b = w[{a, 3'b000} +: 8];
        case (op)
            OP_LH:   r = {{16{SIGN_EXT & h[15]}}, h};
            OP_LB:   r = {{24{SIGN_EXT & b[7]}}, b};
            default: r = w;
        endcase
        return r;
    endfunction

    // Sub-word store: splice the new lane into the word just read back.
    function automatic logic [31:0] merge(input logic [2:0] op, input logic [1:0] a,
                                          input logic [15:0] d, input logic [31:0] w);
        logic [31:0] r;
        r = w;
        if (op == OP_SH) r[{a[1], 4'b0000} +: 16] = d;
        else             r[{a, 3'b000} +: 8]      = d[7:0];
        return r;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_q        <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            align_err_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        op_q       <= bus.op;
                        lane_q     <= bus.addr[1:0];
                        wdata_q    <= bus.wdata[15:0];
                        busy_q     <= 1'b1;
                        mem_addr_q <= {bus.addr[31:2], 2'b00};
                        if (bad_req(bus.op, bus.addr[1:0])) begin
                            state       <= DONE;
                            done_q      <= 1'b1;
                            align_err_q <= 1'b1;
                        end else if (bus.op == OP_SW) begin
                            state       <= WR;
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= bus.wdata;
                        end else begin
                            state <= RD_WAIT;
                            cnt   <= 3'(READ_LAT);
                        end
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (op_q <= OP_LB) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            rdata_q <= extract(op_q, lane_q, bus.mem_rdata);
                        end else begin
                            state       <= WR;
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= merge(op_q, lane_q, wdata_q, bus.mem_rdata);
                        end
                    end
                end
                WR: begin
                    state       <= DONE;
                    mem_wr_q    <= 1'b0;
                    mem_wdata_q <= '0;
                    done_q      <= 1'b1;
                end
                DONE: begin
                    state       <= IDLE;
                    done_q      <= 1'b0;
                    align_err_q <= 1'b0;
                    busy_q      <= 1'b0;
                    mem_addr_q  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - self-checking bench for mem_access_seq at READ_LAT 2/1/4
module tb_mem_access_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    logic [2:0]       req_v = '0;
    logic [2:0][2:0]  op_v = '0;
    logic [2:0][31:0] addr_v = '0;
    logic [2:0][31:0] wdata_v = '0;
    logic [2:0][31:0] mrd_v;
    logic [2:0]       busy_v, done_v, aerr_v, mwr_v;
    logic [2:0][31:0] rdata_v, maddr_v, mwdata_v;

    logic [31:0] mem [3][64];
    logic [31:0] last_addr [3];
    int          age [3];
    logic        mem_init = 1'b1;

    logic [31:0] ref_mem [3][64];
    logic [31:0] ref_rd [3];
    int n_cmp = 0;
    int n_bad = 0;

    genvar g;
    for (g = 0; g < 3; g++) begin : gen_dut
        mem_access_seq_if ifc ();
        assign ifc.req       = req_v[g];
        assign ifc.op        = op_v[g];
        assign ifc.addr      = addr_v[g];
        assign ifc.wdata     = wdata_v[g];
        assign ifc.mem_rdata = mrd_v[g];
        assign busy_v[g]     = ifc.busy;
        assign done_v[g]     = ifc.done;
        assign aerr_v[g]     = ifc.align_err;
        assign rdata_v[g]    = ifc.rdata;
        assign maddr_v[g]    = ifc.mem_addr;
        assign mwr_v[g]      = ifc.mem_wr;
        assign mwdata_v[g]   = ifc.mem_wdata;
        mem_access_seq #(
            .READ_LAT(g == 0 ? 2 : (g == 1 ? 1 : 4)),
            .SIGN_EXT(g == 1)
        ) u_dut (
            .clock(clk),
            .reset(rst_n),
            .bus  (ifc.slave)
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hA1B2C3D4 : (32'h13579BDF ^ (32'(i) * 32'h01010101));
    endfunction

    // Memory returns poison until the word address has been stable for READ_LAT cycles.
    always_comb begin
        mrd_v = '0;
        for (int k = 0; k < 3; k++) begin
            if (lat_of(k) == 1 || (maddr_v[k] == last_addr[k] && age[k] >= lat_of(k) - 1))
                mrd_v[k] = mem[k][maddr_v[k][7:2]];
            else
                mrd_v[k] = 32'hBAD0BAD0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_init) begin
                for (int i = 0; i < 64; i++) mem[k][i] <= init_word(i);
                last_addr[k] <= '0;
                age[k]       <= 0;
            end else begin
                if (mwr_v[k]) mem[k][maddr_v[k][7:2]] <= mwdata_v[k];
                if (maddr_v[k] != last_addr[k]) begin
                    last_addr[k] <= maddr_v[k];
                    age[k]       <= 1;
                end else if (age[k] < 15) begin
                    age[k] <= age[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the instruction semantics.
    task automatic model(input int k, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, output int e_done, output bit e_err,
                         output bit e_wr, output logic [31:0] e_ww, output logic [31:0] e_rd);
        logic [31:0] w, v;
        int sh8, sh16, lat;
        lat  = lat_of(k);
        w    = ref_mem[k][addr[7:2]];
        sh8  = 8 * int'(addr[1:0]);
        sh16 = addr[1] ? 16 : 0;
        e_wr = 0;
        e_ww = '0;
        e_err = (op > 5) || ((op == 0 || op == 3) && addr[1:0] != 0) || ((op == 1 || op == 4) && addr[0]);
        e_done = 1;
        if (!e_err) begin
            case (op)
                3'd0: begin ref_rd[k] = w; e_done = lat + 1; end
                3'd1: begin
                    v = (w >> sh16) & 32'hFFFF;
                    if (k == 1 && v[15]) v = v | 32'hFFFF0000;
                    ref_rd[k] = v; e_done = lat + 1;
                end
                3'd2: begin
                    v = (w >> sh8) & 32'hFF;
                    if (k == 1 && v[7]) v = v | 32'hFFFFFF00;
                    ref_rd[k] = v; e_done = lat + 1;
                end
                3'd3: begin e_wr = 1; e_ww = wdata; e_done = 2; end
                3'd4: begin
                    e_wr = 1; e_done = lat + 2;
                    e_ww = (w & ~(32'hFFFF << sh16)) | ((wdata & 32'hFFFF) << sh16);
                end
                default: begin
                    e_wr = 1; e_done = lat + 2;
                    e_ww = (w & ~(32'hFF << sh8)) | ((wdata & 32'hFF) << sh8);
                end
            endcase
        end
        if (e_wr) ref_mem[k][addr[7:2]] = e_ww;
        e_rd = ref_rd[k];
    endtask

    task automatic run_txn(input int k, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, output int d_cyc, output bit err,
                           output int nwr, output int w_cyc, output logic [31:0] wword,
                           output logic [31:0] rd, output bit clean);
        @(negedge clk);
        req_v[k] = 1'b1; op_v[k] = op; addr_v[k] = addr; wdata_v[k] = wdata;
        @(posedge clk);
        @(negedge clk);
        req_v[k] = 1'b0; op_v[k] = 3'($urandom); addr_v[k] = $urandom; wdata_v[k] = $urandom;
        d_cyc = -1; err = 0; nwr = 0; w_cyc = -1; wword = '0; rd = '0; clean = 1;
        for (int n = 1; n <= 20; n++) begin
            if (!busy_v[k] || maddr_v[k] != {addr[31:2], 2'b00}) clean = 0;
            if (!mwr_v[k] && mwdata_v[k] != 0) clean = 0;
            if (!done_v[k] && aerr_v[k]) clean = 0;
            if (mwr_v[k]) begin nwr++; w_cyc = n; wword = mwdata_v[k]; end
            if (done_v[k]) begin d_cyc = n; err = aerr_v[k]; rd = rdata_v[k]; break; end
            @(negedge clk);
        end
        @(negedge clk);
        if (busy_v[k] || done_v[k] || mwr_v[k] || aerr_v[k] || maddr_v[k] != 0) clean = 0;
    endtask

    task automatic apply(input string tag, input int k, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata, input int e_done,
                         input bit e_err, input bit e_wr, input logic [31:0] e_ww,
                         input logic [31:0] e_rd);
        int d_cyc, nwr, w_cyc;
        bit err, clean;
        logic [31:0] wword, rd;
        run_txn(k, op, addr, wdata, d_cyc, err, nwr, w_cyc, wword, rd, clean);
        chk({tag, " done_cycle"}, 32'(d_cyc), 32'(e_done));
        chk({tag, " align_err"}, 32'(err), 32'(e_err));
        chk({tag, " write_count"}, 32'(nwr), 32'(e_wr));
        if (e_wr) begin
            chk({tag, " write_cycle"}, 32'(w_cyc), 32'(e_done - 1));
            chk({tag, " write_word"}, wword, e_ww);
        end
        chk({tag, " rdata"}, rd, e_rd);
        chk({tag, " protocol"}, 32'(clean), 32'd1);
    endtask

    typedef struct {
        int k; logic [2:0] op; logic [31:0] addr; logic [31:0] wdata;
        int done; bit err; bit wr; logic [31:0] ww; logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(int k, logic [2:0] op, logic [31:0] addr, logic [31:0] wdata,
                                int done, bit err, bit wr, logic [31:0] ww, logic [31:0] rd);
        vec_t v;
        v.k = k; v.op = op; v.addr = addr; v.wdata = wdata;
        v.done = done; v.err = err; v.wr = wr; v.ww = ww; v.rd = rd;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        int e_done, dn, nw, first_d, second_d;
        bit e_err, e_wr, busy4;
        logic [31:0] e_ww, e_rd, e_rd2;

        tbl.push_back(mk(0, 3'd0, 32'h10, 32'h0,        3, 0, 0, 32'h0,        32'hA1B2C3D4));
        tbl.push_back(mk(0, 3'd2, 32'h13, 32'h0,        3, 0, 0, 32'h0,        32'h000000A1));
        tbl.push_back(mk(0, 3'd1, 32'h12, 32'h0,        3, 0, 0, 32'h0,        32'h0000A1B2));
        tbl.push_back(mk(1, 3'd2, 32'h13, 32'h0,        2, 0, 0, 32'h0,        32'hFFFFFFA1));
        tbl.push_back(mk(1, 3'd1, 32'h12, 32'h0,        2, 0, 0, 32'h0,        32'hFFFFA1B2));
        tbl.push_back(mk(1, 3'd0, 32'h10, 32'h0,        2, 0, 0, 32'h0,        32'hA1B2C3D4));
        tbl.push_back(mk(2, 3'd0, 32'h10, 32'h0,        5, 0, 0, 32'h0,        32'hA1B2C3D4));
        tbl.push_back(mk(2, 3'd4, 32'h12, 32'h00001234, 6, 0, 1, 32'h1234C3D4, 32'hA1B2C3D4));
        tbl.push_back(mk(0, 3'd5, 32'h11, 32'h000000EE, 4, 0, 1, 32'hA1B2EED4, 32'h0000A1B2));
        tbl.push_back(mk(0, 3'd3, 32'h20, 32'hCAFEF00D, 2, 0, 1, 32'hCAFEF00D, 32'h0000A1B2));
        tbl.push_back(mk(0, 3'd0, 32'h11, 32'h0,        1, 1, 0, 32'h0,        32'h0000A1B2));
        tbl.push_back(mk(0, 3'd4, 32'h13, 32'h0000FFFF, 1, 1, 0, 32'h0,        32'h0000A1B2));
        tbl.push_back(mk(0, 3'd7, 32'h10, 32'h0,        1, 1, 0, 32'h0,        32'h0000A1B2));
        tbl.push_back(mk(1, 3'd6, 32'h00, 32'h0,        1, 1, 0, 32'h0,        32'hA1B2C3D4));
        tbl.push_back(mk(2, 3'd2, 32'h11, 32'h0,        5, 0, 0, 32'h0,        32'h000000C3));
        tbl.push_back(mk(0, 3'd0, 32'h20, 32'h0,        3, 0, 0, 32'h0,        32'hCAFEF00D));
        tbl.push_back(mk(0, 3'd2, 32'h11, 32'h0,        3, 0, 0, 32'h0,        32'h000000EE));

        for (int k = 0; k < 3; k++) begin
            ref_rd[k] = '0;
            for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
        end

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset%0d busy", k), 32'(busy_v[k]), 32'd0);
            chk($sformatf("reset%0d done", k), 32'(done_v[k]), 32'd0);
            chk($sformatf("reset%0d mem_addr", k), maddr_v[k], 32'd0);
            chk($sformatf("reset%0d rdata", k), rdata_v[k], 32'd0);
        end
        mem_init = 1'b0;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            model(tbl[i].k, tbl[i].op, tbl[i].addr, tbl[i].wdata, e_done, e_err, e_wr, e_ww, e_rd);
            apply($sformatf("vec%0d", i), tbl[i].k, tbl[i].op, tbl[i].addr, tbl[i].wdata,
                  tbl[i].done, tbl[i].err, tbl[i].wr, tbl[i].ww, tbl[i].rd);
        end

        // Reset during the read phase of an SB must abort with no write and no done.
        @(negedge clk);
        req_v[2] = 1'b1; op_v[2] = 3'd5; addr_v[2] = 32'h15; wdata_v[2] = 32'h77;
        @(posedge clk);
        @(negedge clk);
        req_v[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy_v[2]), 32'd0);
        chk("abort done", 32'(done_v[2]), 32'd0);
        chk("abort align_err", 32'(aerr_v[2]), 32'd0);
        chk("abort mem_wr", 32'(mwr_v[2]), 32'd0);
        chk("abort rdata", rdata_v[2], 32'd0);
        chk("abort mem_addr", maddr_v[2], 32'd0);
        chk("abort mem_wdata", mwdata_v[2], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) ref_rd[k] = '0;
        dn = 0; nw = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done_v[2]) dn++;
            if (mwr_v[2]) nw++;
        end
        chk("abort later done", 32'(dn), 32'd0);
        chk("abort later write", 32'(nw), 32'd0);

        // Requests arriving while busy are dropped.
        model(2, 3'd0, 32'h10, 32'h0, e_done, e_err, e_wr, e_ww, e_rd);
        @(negedge clk);
        req_v[2] = 1'b1; op_v[2] = 3'd0; addr_v[2] = 32'h10;
        @(posedge clk);
        dn = 0; nw = 0; first_d = -1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            req_v[2] = (n <= 3);
            op_v[2] = 3'd3; addr_v[2] = 32'h30; wdata_v[2] = $urandom;
            if (done_v[2]) begin dn++; if (first_d < 0) first_d = n; end
            if (mwr_v[2]) nw++;
        end
        req_v[2] = 1'b0;
        chk("busyreq done_count", 32'(dn), 32'd1);
        chk("busyreq done_cycle", 32'(first_d), 32'(e_done));
        chk("busyreq write_count", 32'(nw), 32'd0);
        chk("busyreq rdata", rdata_v[2], e_rd);

        // A req held through DONE is taken only after one IDLE cycle.
        model(0, 3'd0, 32'h20, 32'h0, e_done, e_err, e_wr, e_ww, e_rd);
        model(0, 3'd0, 32'h20, 32'h0, e_done, e_err, e_wr, e_ww, e_rd2);
        @(negedge clk);
        req_v[0] = 1'b1; op_v[0] = 3'd0; addr_v[0] = 32'h20;
        @(posedge clk);
        dn = 0; first_d = -1; second_d = -1; busy4 = 1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 5) req_v[0] = 1'b0;
            if (n == 4) busy4 = busy_v[0];
            if (done_v[0]) begin
                dn++;
                if (first_d < 0) first_d = n; else second_d = n;
            end
        end
        chk("held done_count", 32'(dn), 32'd2);
        chk("held first_done", 32'(first_d), 32'd3);
        chk("held idle_gap_busy", 32'(busy4), 32'd0);
        chk("held second_done", 32'(second_d), 32'd7);
        chk("held rdata", rdata_v[0], e_rd2);

        for (int i = 0; i < 150; i++) begin
            int k;
            logic [2:0] op;
            logic [31:0] addr, wdata;
            k = $urandom_range(0, 2);
            op = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 2) != 0) addr[1:0] = (op == 3'd1 || op == 3'd4) ? {addr[1], 1'b0} : (op == 3'd0 || op == 3'd3) ? 2'b00 : addr[1:0];
            wdata = $urandom;
            model(k, op, addr, wdata, e_done, e_err, e_wr, e_ww, e_rd);
            apply($sformatf("rnd%0d", i), k, op, addr, wdata, e_done, e_err, e_wr, e_ww, e_rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
